// File: rtl/map_pkg.sv
// Shared map-request types and constants used by the map read server and its arbiter.
package map_pkg;

  localparam int MAP_N      = 24;
  localparam int MAP_ADDR_W = $clog2(MAP_N * MAP_N);
  localparam int MAP_DATA_W = 4;

  typedef logic [MAP_ADDR_W-1:0] map_addr_t;
  typedef logic [MAP_DATA_W-1:0] map_cell_t;

  // Cells outside the map read back as a wall
  localparam map_cell_t OOB_WALL = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } map_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2 (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic rr_r;

  // Pick the lone requester, or the pointer's port under contention
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case (req)
      2'b01: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_idx   = rr_r;
      end
      default: begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
      end
    endcase
  end

  // Pointer hands priority to the losing port only when a contended grant is taken
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_r <= 1'b0;
    end else if (accept && (req == 2'b11)) begin
      rr_r <= ~rr_r;
    end
  end

endmodule

// File: rtl/map_read_server.sv
// Map read server: serves map-cell requests from two ports through one BRAM read port.
// Define MAP_RESP_CACHE_EN to add a one-entry response cache per port.
module map_read_server
  import map_pkg::*;
#(
  parameter int        N            = MAP_N,
  parameter int        READ_LATENCY = 2,
  parameter map_cell_t OOB_VALUE    = OOB_WALL
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic [1:0]                    map_request_in,
  input  logic [1:0][$clog2(N*N)-1:0]   map_addra_in,
  output logic [1:0][3:0]               map_data_out,
  output logic [1:0]                    map_data_valid_out,
  output logic [$clog2(N*N)-1:0]        bram_addr_out,
  output logic                          bram_en_out,
  input  logic [3:0]                    bram_data_in,
  output logic                          busy_out
);

  localparam int          AW    = $clog2(N * N);
  localparam int          CW    = $clog2(READ_LATENCY + 1);
  localparam logic [AW:0] CELLS = (AW + 1)'(N * N);

  map_state_e      state_r, state_next_s;
  logic [CW-1:0]   cnt_r, cnt_next_s;
  logic            port_r;
  logic            from_bram_r;
  map_cell_t       cell_r;
  logic [1:0]      valid_r;
  logic [1:0][3:0] data_r;
  logic [AW-1:0]   bram_addr_r;
  logic            bram_en_r;
  logic            busy_r;

  logic [1:0]      eligible_s;
  logic            grant_valid_s;
  logic            grant_idx_s;
  logic            accept_s;
  logic            oob_s;
  logic            hit_s;
  logic [AW-1:0]   grant_addr_s;
  map_cell_t       hit_cell_s;

  // A port is still asserting request during its ack cycle; mask it out
  assign eligible_s   = map_request_in & ~valid_r;
  assign accept_s     = (state_r == ST_IDLE) && grant_valid_s;
  assign grant_addr_s = map_addra_in[grant_idx_s];
  assign oob_s        = ({1'b0, grant_addr_s} >= CELLS);

  rr_arbiter2 u_arb (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .req          (eligible_s),
    .accept       (accept_s),
    .grant_valid  (grant_valid_s),
    .grant_idx    (grant_idx_s)
  );

`ifdef MAP_RESP_CACHE_EN
  logic [1:0]           cache_vld_r;
  logic [1:0][AW-1:0]   cache_tag_r;
  logic [1:0][3:0]      cache_data_r;
  logic [AW-1:0]        addr_r;

  assign hit_s      = cache_vld_r[grant_idx_s] && (cache_tag_r[grant_idx_s] == grant_addr_s);
  assign hit_cell_s = cache_data_r[grant_idx_s];

  // Remember the granted address and refill that port's entry on every BRAM completion
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      cache_vld_r  <= 2'b00;
      cache_tag_r  <= '0;
      cache_data_r <= '0;
      addr_r       <= '0;
    end else begin
      if (accept_s) begin
        addr_r <= grant_addr_s;
      end
      if ((state_r == ST_RESPOND) && from_bram_r) begin
        cache_vld_r[port_r]  <= 1'b1;
        cache_tag_r[port_r]  <= addr_r;
        cache_data_r[port_r] <= bram_data_in;
      end
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_cell_s = OOB_VALUE;
`endif

  // Next-state logic; WAIT holds until the BRAM data arrives in the RESPOND cycle
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (oob_s || hit_s) begin
            state_next_s = ST_RESPOND;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_next_s = CW'(READ_LATENCY - 1);
        if (READ_LATENCY > 1) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_RESPOND;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - CW'(1);
        if (cnt_r <= CW'(1)) begin
          state_next_s = ST_RESPOND;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESPOND: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, transaction latches and registered outputs
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      port_r      <= 1'b0;
      from_bram_r <= 1'b0;
      cell_r      <= '0;
      valid_r     <= 2'b00;
      data_r      <= '0;
      bram_addr_r <= '0;
      bram_en_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      bram_en_r <= 1'b0;
      valid_r   <= 2'b00;
      if (accept_s) begin
        port_r      <= grant_idx_s;
        from_bram_r <= !(oob_s || hit_s);
        cell_r      <= oob_s ? OOB_VALUE : hit_cell_s;
        if (!(oob_s || hit_s)) begin
          bram_en_r   <= 1'b1;
          bram_addr_r <= grant_addr_s;
        end
      end
      // BRAM data is valid exactly in the RESPOND cycle, so it is captured straight to the port
      if (state_r == ST_RESPOND) begin
        valid_r[port_r] <= 1'b1;
        data_r[port_r]  <= from_bram_r ? bram_data_in : cell_r;
      end
    end
  end

  assign map_data_out       = data_r;
  assign map_data_valid_out = valid_r;
  assign bram_addr_out      = bram_addr_r;
  assign bram_en_out        = bram_en_r;
  assign busy_out           = busy_r;

endmodule

// File: tb/tb_map_read_server.sv
// Self-checking bench for map_read_server: vector table, hand sequences and randomized requesters.
module tb_map_read_server;
  import map_pkg::*;

  localparam int N     = 24;
  localparam int CELLS = N * N;
  localparam int RL    = 2;
  localparam int AW    = $clog2(N * N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][3:0]      data_out;
  logic [1:0]           valid;
  logic [AW-1:0]        bram_addr;
  logic                 bram_en;
  logic [3:0]           bram_data;
  logic                 busy;

  map_read_server #(.N(N), .READ_LATENCY(RL), .OOB_VALUE(4'd1)) dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst),
    .map_request_in     (req),
    .map_addra_in       (addr),
    .map_data_out       (data_out),
    .map_data_valid_out (valid),
    .bram_addr_out      (bram_addr),
    .bram_en_out        (bram_en),
    .bram_data_in       (bram_data),
    .busy_out           (busy)
  );

  always #5 clk = ~clk;

  // Map contents and a READ_LATENCY-deep BRAM; junk appears whenever no read was issued
  logic [3:0] mem [CELLS];
  logic [3:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= (bram_en && (int'(bram_addr) < CELLS)) ? mem[int'(bram_addr)] : 4'($urandom);
    pipe2 <= pipe1;
  end
  assign bram_data = pipe2;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            en_count = 0;
  logic [AW-1:0] en_addr = '0;

  // Reference view of each port's cache (only consulted when the cache is built in)
  bit            mc_v [2];
  logic [AW-1:0] mc_a [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bram_en) begin
      en_count++;
      en_addr = bram_addr;
    end
    if (valid != 2'b00) chk("valid_onehot", 32'($onehot(valid)), 32'd1);
  endtask

  function automatic logic [3:0] exp_cell(input logic [AW-1:0] a);
    if (int'(a) >= CELLS) return 4'd1;
    return mem[int'(a)];
  endfunction

  function automatic int exp_lat(input int p, input logic [AW-1:0] a);
    if (int'(a) >= CELLS) return 2;
`ifdef MAP_RESP_CACHE_EN
    if (mc_v[p] && (mc_a[p] == a)) return 2;
`endif
    return 2 + RL;
  endfunction

  task automatic model_done(input int p, input logic [AW-1:0] a);
    if (int'(a) < CELLS) begin
      mc_v[p] = 1'b1;
      mc_a[p] = a;
    end
  endtask

  task automatic wait_valid(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (valid != 2'b00) begin
        k = i;
        break;
      end
    end
  endtask

  // One uncontended request, its ack cycle, then the request is dropped
  task automatic single(input int p, input logic [AW-1:0] a, input logic [3:0] exp_d,
                        input int exp_l, input string tag);
    int k;
    int e0;
    e0 = en_count;
    req[p]  = 1'b1;
    addr[p] = a;
    wait_valid(12, k);
    chk({tag, "_lat"}, k, exp_l);
    chk({tag, "_valid"}, valid, (p == 0) ? 2'b01 : 2'b10);
    chk({tag, "_data"}, data_out[p], exp_d);
    chk({tag, "_bram_reads"}, en_count - e0, (exp_l == 2) ? 0 : 1);
    if (exp_l != 2) chk({tag, "_bram_addr"}, en_addr, a);
    model_done(p, a);
    tick();
    chk({tag, "_pulse_end"}, valid, 2'b00);
    chk({tag, "_idle_after_ack"}, busy, 1'b0);
    chk({tag, "_data_hold"}, data_out[p], exp_d);
    req[p] = 1'b0;
  endtask

  typedef struct {
    int            port;
    logic [AW-1:0] a;
    logic [3:0]    exp_d;
    int            exp_l;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   k, start, bad;
    int   ph [2];
    int   gap [2];
    int   st [2];
    int   nreq, nresp, lat;
    logic [AW-1:0] ra [2];

    for (int i = 0; i < CELLS; i++) mem[i] = 4'((i * 7 + 5) % 16);
    mem[0]  = 4'd1;
    mem[25] = 4'd3;
    mem[26] = 4'd9;
    mc_v[0] = 1'b0;
    mc_v[1] = 1'b0;
    mc_a[0] = '0;
    mc_a[1] = '0;
    req  = 2'b00;
    addr = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 2'b00);
    chk("reset_data", data_out, 8'h00);
    chk("reset_bram", {bram_en, bram_addr}, 0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Uncontended vectors: in-range reads, out-of-bounds addresses, both ports
    tbl[0] = '{0, AW'(25),   4'd3,  4};
    tbl[1] = '{1, AW'(576),  4'd1,  2};
    tbl[2] = '{1, AW'(0),    4'd1,  4};
    tbl[3] = '{0, AW'(575),  4'd14, 4};
    tbl[4] = '{0, AW'(1023), 4'd1,  2};
    tbl[5] = '{1, AW'(26),   4'd9,  4};
    for (int i = 0; i < 6; i++) begin
      single(tbl[i].port, tbl[i].a, tbl[i].exp_d, tbl[i].exp_l, $sformatf("vec%0d", i));
      tick();
    end

    // Contention: port 0 wins first, port 1 is served from port 0's ack cycle
    req = 2'b11;
    addr[0] = AW'(0);
    addr[1] = AW'(600);
    start = cyc;
    wait_valid(12, k);
    chk("cont_first_valid", valid, 2'b01);
    chk("cont_p0_lat", cyc - start, exp_lat(0, AW'(0)));
    chk("cont_p0_data", data_out[0], 4'd1);
    model_done(0, AW'(0));
    tick();
    chk("cont_p1_waiting", valid, 2'b00);
    req[0] = 1'b0;
    wait_valid(12, k);
    chk("cont_second_valid", valid, 2'b10);
    chk("cont_p1_lat", cyc - start, exp_lat(0, AW'(0)) + 2);
    chk("cont_p1_data", data_out[1], 4'd1);
    tick();
    req[1] = 1'b0;
    tick();
    // Second simultaneous pair: the pointer now favours port 1
    req = 2'b11;
    addr[0] = AW'(100);
    addr[1] = AW'(200);
    wait_valid(12, k);
    chk("rr_second_pair_first", valid, 2'b10);
    chk("rr_p1_data", data_out[1], mem[200]);
    model_done(1, AW'(200));
    tick();
    req[1] = 1'b0;
    wait_valid(12, k);
    chk("rr_second_pair_next", valid, 2'b01);
    chk("rr_p0_data", data_out[0], mem[100]);
    model_done(0, AW'(100));
    tick();
    req[0] = 1'b0;
    tick();

    // DDA-style handshake: drop for one cycle, re-raise with the next cell
    single(0, AW'(25), exp_cell(AW'(25)), exp_lat(0, AW'(25)), "dda_a");
    tick();
    chk("dda_no_dup", valid, 2'b00);
    single(0, AW'(26), exp_cell(AW'(26)), exp_lat(0, AW'(26)), "dda_b");
    tick();

    // Reset while the read is outstanding
    req[0]  = 1'b1;
    addr[0] = AW'(300);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {valid, data_out, bram_en, bram_addr, busy}, 0);
    mc_v[0] = 1'b0;
    mc_v[1] = 1'b0;
    req[0]  = 1'b0;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid != 2'b00 || busy) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    single(1, AW'(25), 4'd3, 4, "post_rst");
    tick();

    // Repeat reads of one cell: cached per port when the cache is built in
    single(0, AW'(25), exp_cell(AW'(25)), exp_lat(0, AW'(25)), "rep_first");
    tick();
    single(0, AW'(25), exp_cell(AW'(25)), exp_lat(0, AW'(25)), "rep_second");
    tick();
    single(1, AW'(25), exp_cell(AW'(25)), exp_lat(1, AW'(25)), "rep_other");
    tick();

    // Randomized DDA-style requesters on both ports
    ph[0] = 0; ph[1] = 0;
    gap[0] = 0; gap[1] = 1;
    st[0] = 0; st[1] = 0;
    ra[0] = '0; ra[1] = '0;
    nreq = 0;
    nresp = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (valid[p]) begin
          if (ph[p] != 1) begin
            chk("rnd_unrequested_valid", ph[p], 1);
          end else begin
            lat = cyc - st[p];
            chk("rnd_data", data_out[p], exp_cell(ra[p]));
            chk("rnd_wait_bound", (lat >= 2) && (lat <= 8), 1'b1);
            nresp++;
            model_done(p, ra[p]);
            ph[p] = 2;
          end
        end else if (ph[p] == 1 && (cyc - st[p]) > 10) begin
          chk("rnd_timeout", cyc - st[p], 8);
          req[p] = 1'b0;
          ph[p] = 0;
          gap[p] = 1;
        end else if (ph[p] == 2) begin
          req[p] = 1'b0;
          ph[p]  = 0;
          gap[p] = int'($urandom_range(2, 0));
        end else if (ph[p] == 0) begin
          if (gap[p] > 0) begin
            gap[p]--;
          end else if (c < 470) begin
            k = int'($urandom_range(7, 0));
            if (k == 0)     ra[p] = AW'(576 + $urandom_range(447, 0));
            else if (k < 3) ra[p] = ra[p];
            else            ra[p] = AW'($urandom_range(575, 0));
            addr[p] = ra[p];
            req[p]  = 1'b1;
            st[p]   = cyc;
            ph[p]   = 1;
            nreq++;
          end
        end
      end
    end
    chk("rnd_all_served", nresp, nreq);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
